// File: rtl/regfiletmp_commit_pkg.sv
// ============================================================================
// Module   : regfiletmp_commit_pkg
// Brief    : Shared temp-file entry layout, type encodings and sizing.
// Revision : 1.0
// ============================================================================
`default_nettype none

package regfiletmp_commit_pkg;

    localparam int c_depth   = 32;
    localparam int c_aw      = 5;
    localparam int c_entry_w = 73;

    localparam int c_rd_msb         = 72;
    localparam int c_rd_lsb         = 68;
    localparam int c_pc_msb         = 67;
    localparam int c_pc_lsb         = 36;
    localparam int c_type_msb       = 35;
    localparam int c_type_lsb       = 34;
    localparam int c_spec_data_msb  = 33;
    localparam int c_spec_data_lsb  = 2;
    localparam int c_spec_valid_bit = 1;
    localparam int c_valid_bit      = 0;

    localparam logic [1:0] c_type_alu    = 2'b00;
    localparam logic [1:0] c_type_load   = 2'b01;
    localparam logic [1:0] c_type_store  = 2'b10;
    localparam logic [1:0] c_type_branch = 2'b11;

    typedef enum logic [0:0] {
        ST_NORMAL  = 1'b0,
        ST_FLUSHED = 1'b1
    } state_t;

    // Only register-producing instructions with a non-zero destination update the ARF.
    function automatic logic writes_arf(input logic [1:0] typ, input logic [4:0] rd);
        logic produces;
        case (typ)
            c_type_alu, c_type_load:     produces = 1'b1;
            c_type_store, c_type_branch: produces = 1'b0;
            default:                     produces = 1'b0;
        endcase
        return produces && (rd != 5'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfiletmp_commit_ring_ptr.sv
// ============================================================================
// Module   : regfiletmp_commit_ring_ptr
// Brief    : AW-bit wrapping pointer with synchronous clear and increment.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfiletmp_commit_ring_ptr #(
    parameter int AW = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] r_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (clear) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/regfiletmp_commit.sv
// ============================================================================
// Module   : regfiletmp_commit
// Brief    : In-order tag allocation and retirement for the temp register file.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfiletmp_commit
    import regfiletmp_commit_pkg::*;
#(
    parameter int DEPTH = c_depth,
    parameter int AW    = c_aw
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 alloc_req,
    output logic                 alloc_gnt,
    output logic [AW-1:0]        alloc_tag,
    output logic                 full,
    output logic                 empty,
    output logic [AW-1:0]        head_addr,
    input  logic [c_entry_w-1:0] head_data,
    input  logic                 commit_stall,
    output logic                 commit_valid,
    output logic [31:0]          commit_pc,
    output logic [1:0]           commit_type,
    output logic                 arf_we,
    output logic [4:0]           arf_waddr,
    output logic [31:0]          arf_wdata
);

    localparam logic [AW:0] c_full_count = DEPTH[AW:0];
    localparam logic [AW:0] c_one        = {{AW{1'b0}}, 1'b1};

    state_t        r_state;
    logic [AW:0]   r_count;
    logic [AW-1:0] w_head;
    logic [AW-1:0] w_tail;
    logic          w_normal;
    logic          w_full;
    logic          w_empty;
    logic          w_gnt;
    logic          w_rdy;

    logic          r_commit_valid;
    logic [31:0]   r_commit_pc;
    logic [1:0]    r_commit_type;
    logic          r_arf_we;
    logic [4:0]    r_arf_waddr;
    logic [31:0]   r_arf_wdata;

    logic [4:0]    w_rd;
    logic [31:0]   w_pc;
    logic [1:0]    w_type;
    logic [31:0]   w_spec_data;

    assign w_rd        = head_data[c_rd_msb:c_rd_lsb];
    assign w_pc        = head_data[c_pc_msb:c_pc_lsb];
    assign w_type      = head_data[c_type_msb:c_type_lsb];
    assign w_spec_data = head_data[c_spec_data_msb:c_spec_data_lsb];

    assign w_normal = (r_state == ST_NORMAL);
    assign w_full   = (r_count == c_full_count);
    assign w_empty  = (r_count == '0);

    // Full is judged on the registered count, so a slot freed this cycle is grantable next cycle.
    assign w_gnt = alloc_req && !w_full && w_normal && !flush;
    assign w_rdy = !w_empty && head_data[c_valid_bit] && head_data[c_spec_valid_bit]
                   && !commit_stall && w_normal && !flush;

    regfiletmp_commit_ring_ptr #(.AW(AW)) u_head_ptr (
        .clock (clock),
        .reset (reset),
        .clear (flush),
        .inc   (w_rdy),
        .ptr   (w_head)
    );

    regfiletmp_commit_ring_ptr #(.AW(AW)) u_tail_ptr (
        .clock (clock),
        .reset (reset),
        .clear (flush),
        .inc   (w_gnt),
        .ptr   (w_tail)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_NORMAL;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_pc    <= '0;
            r_commit_type  <= '0;
            r_arf_we       <= 1'b0;
            r_arf_waddr    <= '0;
            r_arf_wdata    <= '0;
        end else begin
            r_commit_valid <= w_rdy;
            r_arf_we       <= w_rdy && writes_arf(w_type, w_rd);
            if (w_rdy) begin
                r_commit_pc   <= w_pc;
                r_commit_type <= w_type;
                r_arf_waddr   <= w_rd;
                r_arf_wdata   <= w_spec_data;
            end

            // Flush wins over grant and commit; FLUSHED always lasts a single cycle.
            if (flush) begin
                r_state <= ST_FLUSHED;
                r_count <= '0;
            end else begin
                r_state <= ST_NORMAL;
                if (w_gnt && !w_rdy) begin
                    r_count <= r_count + c_one;
                end else if (!w_gnt && w_rdy) begin
                    r_count <= r_count - c_one;
                end
            end
        end
    end

    assign alloc_gnt    = w_gnt;
    assign alloc_tag    = w_tail;
    assign head_addr    = w_head;
    assign full         = w_full;
    assign empty        = w_empty;
    assign commit_valid = r_commit_valid;
    assign commit_pc    = r_commit_pc;
    assign commit_type  = r_commit_type;
    assign arf_we       = r_arf_we;
    assign arf_waddr    = r_arf_waddr;
    assign arf_wdata    = r_arf_wdata;

endmodule

`default_nettype wire
